teller_scheduler: RTL

Dispatch controller for the bank queue: moves customers from the queue up/down counter to free tellers. Round-robin assignment over up to three staffed tellers, a per-teller service timer, and a req/ack dequeue handshake to the queue counter. Also drives the 2-bit active-teller count consumed by the wait-time ROM and keeps a served-customer total.

---
 rtl/teller_scheduler.sv | 133 +++++++++++++
 1 files changed

// File: rtl/teller_scheduler.sv
`timescale 1ns/1ps
// teller_scheduler: round-robin dispatch of queued customers to free tellers,
// with per-teller service timers, a dequeue req/ack handshake and a served total.
module teller_scheduler #(
    parameter int NTELLER   = 3,
    parameter int SVC_TICKS = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tick,
    input  logic [3:0]         qcount,
    input  logic [NTELLER-1:0] teller_en,
    input  logic [NTELLER-1:0] done,
    input  logic               deq_ack,
    output logic               deq_req,
    output logic [1:0]         assign_id,
    output logic [NTELLER-1:0] busy,
    output logic [1:0]         tcount,
    output logic [7:0]         served
);

    typedef enum logic [1:0] {IDLE, REQ, GAP} state_t;

    state_t             state_q, state_d;
    logic [1:0]         target_q, target_d;
    logic [1:0]         rrPtr_q, rrPtr_d;
    logic [NTELLER-1:0] busy_q, busy_d;
    logic [7:0]         timer_q [NTELLER];
    logic [7:0]         timer_d [NTELLER];
    logic [7:0]         served_q, served_d;
    logic [1:0]         tcount_q, tcount_d;

    logic [NTELLER-1:0] eligible;
    logic [NTELLER-1:0] complete;
    logic [1:0]         numDone;
    logic               found;
    logic [1:0]         pick;
    logic [2:0]         idx;

    assign eligible = teller_en & ~busy_q;

    // First eligible teller after the round-robin pointer, wrapping at NTELLER.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = '0;
        for (int k = 1; k <= NTELLER; k++) begin
            idx = {1'b0, rrPtr_q} + 3'(k);
            if (idx >= 3'(NTELLER)) begin
                idx = idx - 3'(NTELLER);
            end
            if (!found && eligible[idx[1:0]]) begin
                found = 1'b1;
                pick  = idx[1:0];
            end
        end
    end

    always_comb begin
        busy_d   = busy_q;
        complete = '0;
        numDone  = '0;
        state_d  = state_q;
        target_d = target_q;
        rrPtr_d  = rrPtr_q;
        tcount_d = '0;
        for (int i = 0; i < NTELLER; i++) begin
            timer_d[i]  = timer_q[i];
            complete[i] = busy_q[i] && (done[i] || (tick && timer_q[i] == 8'd1));
            if (busy_q[i] && tick && timer_q[i] != 8'd0) begin
                timer_d[i] = timer_q[i] - 8'd1;
            end
            if (complete[i]) begin
                busy_d[i]  = 1'b0;
                timer_d[i] = 8'd0;
            end
            numDone  = numDone + 2'(complete[i]);
            tcount_d = tcount_d + 2'(teller_en[i]);
        end
        served_d = served_q + 8'(numDone);

        // An ack is applied after completions so a reload wins over a same-edge finish.
        unique case (state_q)
            IDLE: begin
                if (qcount != 4'd0 && found) begin
                    state_d  = REQ;
                    target_d = pick;
                    rrPtr_d  = pick;
                end
            end
            REQ: begin
                if (deq_ack) begin
                    busy_d[target_q]  = 1'b1;
                    timer_d[target_q] = 8'(SVC_TICKS);
                    state_d           = GAP;
                end
            end
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            target_q <= '0;
            rrPtr_q  <= 2'(NTELLER - 1);
            busy_q   <= '0;
            served_q <= '0;
            tcount_q <= '0;
            for (int i = 0; i < NTELLER; i++) begin
                timer_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            rrPtr_q  <= rrPtr_d;
            busy_q   <= busy_d;
            served_q <= served_d;
            tcount_q <= tcount_d;
            for (int i = 0; i < NTELLER; i++) begin
                timer_q[i] <= timer_d[i];
            end
        end
    end

    assign deq_req   = (state_q == REQ);
    assign assign_id = deq_req ? target_q : 2'd0;
    assign busy      = busy_q;
    assign tcount    = tcount_q;
    assign served    = served_q;

endmodule
